// File: rtl/mod_enc_multiplicator.sv
// 4x4 unsigned byte matrix multiplier, one-cycle registered latency.
// Each output byte is the low 8 bits of its 18-bit dot product; carry flags row overflow.
module mod_enc_multiplicator (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0][7:0] matA,
  input  logic [15:0][7:0] matB,
  output logic [15:0][7:0] out,
  output logic [3:0]       carry
);

  logic [17:0]      sumFull [16];
  logic [15:0][7:0] nextOut;
  logic [3:0]       nextCarry;

  function automatic logic [17:0] dotRow(input logic [3:0][7:0] a,
                                         input logic [3:0][7:0] b);
    logic [17:0] acc;
    logic [15:0] prod;
    acc = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      prod = a[k] * b[k];
      acc  = acc + {2'b00, prod};
    end
    return acc;
  endfunction

  for (genvar r = 0; r < 4; r++) begin : gRow
    for (genvar c = 0; c < 4; c++) begin : gCol
      logic [3:0][7:0] rowA;
      logic [3:0][7:0] colB;
      assign rowA = matA[4*r +: 4];
      // index k of colB is B[k][c], so it lines up with rowA[k] = A[r][k]
      assign colB = {matB[12+c], matB[8+c], matB[4+c], matB[c]};
      assign sumFull[4*r+c] = dotRow(rowA, colB);
    end
  end

  always_comb begin
    nextOut   = '0;
    nextCarry = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        nextOut[4*r+c] = sumFull[4*r+c][7:0];
        nextCarry[r]   = nextCarry[r] | (|sumFull[4*r+c][17:8]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      carry <= '0;
    end else begin
      out   <= nextOut;
      carry <= nextCarry;
    end
  end

endmodule

// File: tb/tb_mod_enc_multiplicator.sv
// Directed self-checking bench for mod_enc_multiplicator with hand-computed expectations.
module tb_mod_enc_multiplicator;

  logic             clk;
  logic             rst_n;
  logic [15:0][7:0] matA;
  logic [15:0][7:0] matB;
  logic [15:0][7:0] out;
  logic [3:0]       carry;

  int passCount = 0;
  int totalCount = 0;

  mod_enc_multiplicator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .matA  (matA),
    .matB  (matB),
    .out   (out),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0][7:0] rowsOf(input logic [7:0] r0, input logic [7:0] r1,
                                              input logic [7:0] r2, input logic [7:0] r3);
    logic [15:0][7:0] m;
    for (int c = 0; c < 4; c++) begin
      m[c] = r0; m[4+c] = r1; m[8+c] = r2; m[12+c] = r3;
    end
    return m;
  endfunction

  task automatic chkOut(input string tag, input logic [15:0][7:0] expOut);
    totalCount++;
    assert (out === expOut) passCount++;
    else $error("FAIL %s out observed=%h expected=%h", tag, out, expOut);
  endtask

  task automatic chkCarry(input string tag, input logic [3:0] expCarry);
    totalCount++;
    assert (carry === expCarry) passCount++;
    else $error("FAIL %s carry observed=%b expected=%b", tag, carry, expCarry);
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  logic [15:0][7:0] rampA, rampB, rampC;
  logic [15:0][7:0] identA, identB;
  logic [15:0][7:0] allFF, allFour;
  logic [15:0][7:0] rowA2, onesB;
  logic [15:0][7:0] mixA, mixB, mixC;
  logic [15:0][7:0] holdOut;
  logic [3:0]       holdCarry;

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        rampA[4*r+c] = 8'(10*r + c);
    rampB   = rowsOf(8'd0, 8'd1, 8'd2, 8'd3);
    rampC   = rowsOf(8'd14, 8'd74, 8'd134, 8'd194);
    for (int i = 0; i < 16; i++) identA[i] = 8'(i);
    identB  = '0;
    for (int i = 0; i < 4; i++) identB[5*i] = 8'd1;
    allFF   = rowsOf(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    allFour = rowsOf(8'h04, 8'h04, 8'h04, 8'h04);
    rowA2   = rowsOf(8'h00, 8'h00, 8'h80, 8'h00);
    onesB   = rowsOf(8'h01, 8'h01, 8'h01, 8'h01);
    // C[0][0]=255 (no carry) next to C[0][1]=510; row 1 sits exactly at 255
    mixA = '0;
    mixA[0] = 8'd255; mixA[5] = 8'd51; mixA[8] = 8'd1; mixA[14] = 8'd2;
    mixB = '0;
    mixB[0] = 8'd1; mixB[1] = 8'd2;
    for (int c = 0; c < 4; c++) mixB[4+c] = 8'd5;
    mixB[8] = 8'd200; mixB[9] = 8'd100;
    mixC = '0;
    mixC[0] = 8'hFF; mixC[1] = 8'hFE;
    for (int c = 0; c < 4; c++) mixC[4+c] = 8'hFF;
    mixC[8] = 8'h01; mixC[9] = 8'h02;
    mixC[12] = 8'h90; mixC[13] = 8'hC8;

    // reset held with nonzero inputs and a running clock
    rst_n = 1'b0;
    matA = allFF;
    matB = allFF;
    repeat (3) stepEdge();
    chkOut("reset_hold", '0);
    chkCarry("reset_hold", 4'b0000);

    // first result one edge after reset release
    @(negedge clk);
    rst_n = 1'b1;
    matA = rampA;
    matB = rampB;
    stepEdge();
    chkOut("ramp", rampC);
    chkCarry("ramp", 4'b0000);

    // outputs hold between edges while inputs change
    holdOut = out;
    holdCarry = carry;
    matA = allFF;
    matB = allFF;
    #2;
    chkOut("hold", rampC);
    chkCarry("hold", 4'b0000);
    stepEdge();
    chkOut("overflow", allFour);
    chkCarry("overflow", 4'b1111);

    matA = identA;
    matB = identB;
    stepEdge();
    chkOut("identity", identA);
    chkCarry("identity", 4'b0000);

    matA = rowA2;
    matB = onesB;
    stepEdge();
    chkOut("row2_ovf", '0);
    chkCarry("row2_ovf", 4'b0100);

    matA = mixA;
    matB = mixB;
    stepEdge();
    chkOut("mixed", mixC);
    chkCarry("mixed", 4'b1001);

    // back-to-back ramp then overflow
    matA = rampA;
    matB = rampB;
    stepEdge();
    chkOut("pipe_ramp", rampC);
    chkCarry("pipe_ramp", 4'b0000);
    matA = allFF;
    matB = allFF;
    stepEdge();
    chkOut("pipe_ovf", allFour);
    chkCarry("pipe_ovf", 4'b1111);

    // asynchronous reset between edges clears immediately
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chkOut("async_rst", '0);
    chkCarry("async_rst", 4'b0000);

    // release and recover with the identity vector
    @(negedge clk);
    rst_n = 1'b1;
    matA = identA;
    matB = identB;
    stepEdge();
    chkOut("post_rst", identA);
    chkCarry("post_rst", 4'b0000);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/mod_enc_multiplicator.md
MOD_ENC_MULTIPLICATOR -- requirements
Module: mod_enc_multiplicator

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous, active-low.
REQ-004 matA  input  [15:0][7:0]  4x4 matrix A, unsigned bytes, row-major (element r,c at index 4*r+c, bits 8*(4r+c)+7 : 8*(4r+c)).
REQ-005 matB  input  [15:0][7:0]  4x4 matrix B, same layout as matA.
REQ-006 out  output  [15:0][7:0]  4x4 product matrix C, same row-major layout, registered.
REQ-007 carry  output  [3:0]  Per-row overflow flag; carry[r] covers row r of C, registered.

Function
REQ-008 The block SHALL compute the integer matrix product C = A x B, with C[r][c] = sum over k=0..3 of A[r][k]*B[k][c].
REQ-009 Each product term SHALL be computed at full 16-bit width, and each sum at full 18-bit width (max 4*255*255 = 260100); no intermediate truncation.
REQ-010 out[4r+c] SHALL be the full sum modulo 256 (low 8 bits).
REQ-011 carry[r] SHALL be 1 when any of the four full sums in row r exceeds 255, else 0.
REQ-012 matA and matB SHALL be sampled on every rising clk edge with rst_n high; no handshake, no enable.
REQ-013 Latency SHALL be exactly one cycle: out and carry reflect the inputs present at the previous rising edge.
REQ-014 A new result SHALL be produced every cycle (throughput 1 matrix/cycle); back-to-back input changes are independent.
REQ-015 Arithmetic SHALL be unsigned; inputs with bit 7 set are treated as values 128..255.
REQ-016 Between edges, out and carry SHALL hold stable regardless of input changes.

Reset
REQ-017 While rst_n is low, out SHALL be all zero and carry SHALL be 4'b0000, asynchronously (without waiting for clk).
REQ-018 Asserting rst_n low mid-operation SHALL clear out and carry immediately; the in-flight result is discarded.
REQ-019 After rst_n deasserts, the first valid result SHALL appear one rising edge after the first edge that samples inputs with rst_n high.

Verification
REQ-020 Reset: rst_n=0 with arbitrary matA/matB, clk toggling -> out=0, carry=0000; assert rst_n low between edges -> outputs clear before next edge.
REQ-021 Ramp: matA rows {0,1,2,3},{10,11,12,13},{20,21,22,23},{30,31,32,33}; matB rows {0,0,0,0},{1,1,1,1},{2,2,2,2},{3,3,3,3} -> after one edge, C rows all 14, all 74, all 134, all 194; carry=0000.
REQ-022 Identity: matB = identity (1 on diagonal, 0 elsewhere), matA = bytes 0x00..0x0F -> out equals matA; carry=0000.
REQ-023 Overflow: matA and matB all 0xFF -> every entry 260100 = 0x3F804 -> out all 0x04; carry=1111.
REQ-024 Single-row overflow: matA row 2 all 0x80, other rows 0; matB all 0x01 -> row 2 entries 512 -> 0x00, carry=0100; other rows 0.
REQ-025 Pipelining: apply ramp vector then overflow vector on consecutive edges -> outputs show ramp result then overflow result on consecutive cycles, with no mixing.
